// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Size codes, FSM states and default RAM depth.
package dmem_pkg;

  localparam int DEPTH_DEF = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_MERGE,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/dmem_lane.sv
// Byte/half lane extraction for loads and lane merge for stores.
// Purely combinational; shared by the capture and merge paths.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // select the addressed byte and halfword of the RAM word
  always_comb begin
    lane_b = word[8*offset +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
  end

  // extend the selected lane into a full load result
  always_comb begin
    ldata = word;
    unique case (1'b1)
      (size == SZ_BYTE):
        ldata = {{24{sgn & lane_b[7]}}, lane_b};
      (size == SZ_HALF):
        ldata = {{16{sgn & lane_h[15]}}, lane_h};
      default:
        ldata = word;
    endcase
  end

  // replace the addressed lane with right-aligned store data
  always_comb begin
    mdata = word;
    unique case (1'b1)
      (size == SZ_BYTE):
        mdata[8*offset +: 8] = wdata[7:0];
      (size == SZ_HALF):
        mdata[16*offset[1] +: 16] = wdata[15:0];
      default:
        mdata = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-organised synchronous data RAM.
// Sub-word stores are done as read-modify-write.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic        mem_rena,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic        issue_err;
  logic [31:0] ldata;
  logic [31:0] mdata;
  logic        ena_c;
  logic        wena_c;
  logic        rena_c;
  logic [31:0] wd_c;

  dmem_lane u_lane (
    .word   (mem_rdata),
    .wdata  (wdata_q),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .sgn    (sgn_q),
    .ldata  (ldata),
    .mdata  (mdata)
  );

  // alignment, reserved-size and range check on the latched request
  always_comb begin
    issue_err = (size_q == SZ_RSV)
              | ((size_q == SZ_HALF) & addr_q[0])
              | ((size_q == SZ_WORD) & (|addr_q[1:0]))
              | (addr_q[31:2] >= 30'(DEPTH));
  end

  // request latch and sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= 1'b0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          err_q <= issue_err;
          if (issue_err)
            state <= ST_RESP;
          else if (!we_q)
            state <= ST_CAPTURE;
          else if (size_q == SZ_WORD)
            state <= ST_RESP;
          else
            state <= ST_MERGE;
        end
        ST_CAPTURE: state <= ST_IDLE;
        ST_MERGE:   state <= ST_RESP;
        ST_RESP:    state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // RAM strobes and write data decoded from state
  always_comb begin
    ena_c  = 1'b0;
    wena_c = 1'b0;
    rena_c = 1'b0;
    wd_c   = '0;
    unique case (state)
      ST_ISSUE: begin
        if (!issue_err) begin
          ena_c = 1'b1;
          if (we_q && size_q == SZ_WORD) begin
            wena_c = 1'b1;
            wd_c   = wdata_q;
          end else begin
            rena_c = 1'b1;
          end
        end
      end
      ST_MERGE: begin
        ena_c  = 1'b1;
        wena_c = 1'b1;
        wd_c   = mdata;
      end
      default: ;
    endcase
  end

  // gate RAM port with reset; idle address/data forced to zero
  always_comb begin
    mem_ena   = ena_c & ~rst;
    mem_wena  = wena_c & ~rst;
    mem_rena  = rena_c & ~rst;
    mem_addr  = mem_ena ?
      {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]} : '0;
    mem_wdata = mem_ena ? wd_c : '0;
  end

  // handshake and response outputs
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = ~rst & ((state == ST_CAPTURE)
                       | (state == ST_RESP));
    resp_err   = ~rst & (state == ST_RESP) & err_q;
    resp_rdata = (~rst & (state == ST_CAPTURE)) ?
                 ldata : '0;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus random traffic
// checked against a word-array reference model.
module tb_dmem_lsu;

  logic        clk = 0;
  logic        rst = 1;
  logic        clr = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_we = 0;
  logic [1:0]  req_size = 0;
  logic        req_signed = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ena;
  logic        mem_wena;
  logic        mem_rena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:1023];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  dmem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .mem_ena(mem_ena), .mem_wena(mem_wena),
    .mem_rena(mem_rena), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM; junk on the read port when not reading
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_ena && mem_wena && mem_addr < 1024)
        ram[mem_addr[9:0]] <= mem_wdata;
      if (mem_ena && mem_rena && mem_addr < 1024)
        mem_rdata <= ram[mem_addr[9:0]];
      else
        mem_rdata <= $urandom;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] sz,
                                   input logic [31:0] a);
    return (sz == 3) || (sz == 1 && a % 2 != 0) ||
           (sz == 2 && a % 4 != 0) || (a / 4 >= 1024);
  endfunction

  function automatic logic [31:0] ref_load(
      input logic [31:0] w, input logic [1:0] sz,
      input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int off;
    off = a % 4;
    if (sz == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 128) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (sg && v >= 32768) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(
      input logic [31:0] w, input logic [1:0] sz,
      input logic [31:0] wd, input logic [31:0] a);
    logic [31:0] m;
    int off;
    off = a % 4;
    if (sz == 0) begin
      m = 32'hFF << (8 * off);
      return (w & ~m) | ((wd & 32'hFF) << (8 * off));
    end else if (sz == 1) begin
      m = 32'hFFFF << (16 * (off / 2));
      return (w & ~m) | ((wd & 32'hFFFF) << (16 * (off / 2)));
    end
    return wd;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic er, output logic ena_seen,
                        output int wcnt, output logic [31:0] wa);
    int to;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_valid = 1;
    to = 0;
    while (!req_ready && to < 20) begin
      @(negedge clk);
      to++;
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    req_addr = $urandom;
    req_wdata = $urandom;
    lat = 0; rd = 0; er = 0; ena_seen = 0;
    wcnt = 0; wa = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      ena_seen = ena_seen | mem_ena;
      if (mem_wena) begin
        wcnt++;
        wa = mem_addr;
      end
      if (resp_valid) begin
        rd = resp_rdata;
        er = resp_err;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic we,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    int lat, wcnt, explat, idx;
    logic er, ena, experr;
    logic [31:0] wa, exprd;
    experr = ref_err(sz, a);
    idx = (a / 4) % 1024;
    exprd = 0;
    if (experr) explat = 2;
    else if (!we) explat = 2;
    else if (sz == 2) explat = 2;
    else explat = 3;
    if (!experr && !we)
      exprd = ref_load(ref_mem[idx], sz, sg, a);
    if (!experr && we)
      ref_mem[idx] = ref_store(ref_mem[idx], sz, wd, a);
    do_req(we, sz, sg, a, wd, lat, rd, er, ena, wcnt, wa);
    chk({tag, "_lat"}, lat, explat);
    chk({tag, "_err"}, er, experr);
    chk({tag, "_rdata"}, rd, exprd);
    if (experr) chk({tag, "_ena"}, ena, 0);
    if (we && !experr) begin
      chk({tag, "_wcnt"}, wcnt, 1);
      chk({tag, "_waddr"}, wa, a / 4);
      chk({tag, "_ram"}, ram[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int t0, t1, t2, to;
    logic [31:0] ba [3];
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_ena", mem_ena, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    clr = 0;
    rst = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);

    run("sw10", 1, 2, 0, 32'h10, 32'hDEADBEEF, rd);
    chk("sw10_ramc", ram[4], 32'hDEADBEEF);
    run("lw10", 0, 2, 0, 32'h10, 0, rd);
    chk("lw10_c", rd, 32'hDEADBEEF);

    run("sw_pat", 1, 2, 0, 32'h10, 32'h80FF7F01, rd);
    run("lb11", 0, 0, 1, 32'h11, 0, rd);
    chk("lb11_c", rd, 32'h0000007F);
    run("lb12", 0, 0, 1, 32'h12, 0, rd);
    chk("lb12_c", rd, 32'hFFFFFFFF);
    run("lbu13", 0, 0, 0, 32'h13, 0, rd);
    chk("lbu13_c", rd, 32'h00000080);
    run("lh12", 0, 1, 1, 32'h12, 0, rd);
    chk("lh12_c", rd, 32'hFFFF80FF);

    run("sw_rmw", 1, 2, 0, 32'h10, 32'h11223344, rd);
    run("sb11", 1, 0, 0, 32'h11, 32'h123456AA, rd);
    chk("sb11_c", ram[4], 32'h1122AA44);
    run("sh12", 1, 1, 0, 32'h12, 32'h9999BEEF, rd);
    chk("sh12_c", ram[4], 32'hBEEFAA44);

    run("e_lw02", 0, 2, 0, 32'h02, 0, rd);
    run("e_lh03", 0, 1, 1, 32'h03, 0, rd);
    run("e_rsv", 0, 3, 0, 32'h20, 0, rd);
    run("e_sw1000", 1, 2, 0, 32'h1000, 32'h5A5A5A5A, rd);

    // reset asserted during the merge cycle of a byte store
    run("sw20", 1, 2, 0, 32'h20, 32'h55667788, rd);
    @(negedge clk);
    req_we = 1; req_size = 0; req_signed = 0;
    req_addr = 32'h21; req_wdata = 32'h99; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("mr_issue_rena", mem_rena, 1);
    @(negedge clk);
    chk("mr_merge_wena", mem_wena, 1);
    rst = 1;
    #1;
    chk("mr_rst_wena", mem_wena, 0);
    chk("mr_rst_ena", mem_ena, 0);
    chk("mr_rst_resp", resp_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mr_ready", req_ready, 1);
    chk("mr_no_resp", resp_valid, 0);
    chk("mr_ram", ram[8], 32'h55667788);
    @(negedge clk);
    chk("mr_no_resp2", resp_valid, 0);

    // three loads with req_valid held high throughout
    ba[0] = 32'h10; ba[1] = 32'h20; ba[2] = 32'h12;
    t0 = 0; t1 = 0; t2 = 0;
    for (int k = 0; k < 3; k++) begin
      int lat;
      logic [31:0] exp;
      req_we = 0; req_size = (k == 2) ? 2'd1 : 2'd2;
      req_signed = 0; req_addr = ba[k]; req_valid = 1;
      exp = ref_load(ref_mem[ba[k] / 4], req_size, 0, ba[k]);
      to = 0;
      @(negedge clk);
      while (!req_ready && to < 20) begin
        @(negedge clk);
        to++;
      end
      if (k == 0) t0 = cyc;
      else if (k == 1) t1 = cyc;
      else t2 = cyc;
      @(posedge clk);
      #1;
      if (k == 2) req_valid = 0;
      lat = 0;
      while (lat < 10) begin
        @(negedge clk);
        lat++;
        if (resp_valid) break;
      end
      chk($sformatf("b2b_lat%0d", k), lat, 2);
      chk($sformatf("b2b_rd%0d", k), resp_rdata, exp);
    end
    chk("b2b_gap01", t1 - t0, 3);
    chk("b2b_gap12", t2 - t1, 3);

    // random traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
        a = 32'h1000 + ($urandom & 32'hFFF);
      else
        a = $urandom_range(0, 255);
      run($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
